regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the 8-entry register file among NREQ requesters.
//  Round-robin arbitration; drives W_Adr/Din/we_pulse; returns a one-cycle grant per completed write.
//  Sits directly in front of the register file's write port; R/S read ports are not touched.
// PARAMETERS
//  NREQ    4  number of requesters (2..8)
//  ADR_W   3  register address width (NREG = 2**ADR_W)
//  DATA_W  4  write data width (matches register file Din)
// PORTS
//  clk       in   1             system clock, all logic on posedge
//  reset     in   1             synchronous, active-low reset (0 = reset)
//  req       in   NREQ          per-requester write request, held until matching gnt
//  req_adr   in   NREQ*ADR_W    packed target addresses, requester i at [i*ADR_W +: ADR_W]
//  req_din   in   NREQ*DATA_W   packed write data, requester i at [i*DATA_W +: DATA_W]
//  gnt       out  NREQ          one-hot, one-cycle pulse: write for that requester is issued
//  W_Adr     out  ADR_W         register file write address
//  Din       out  DATA_W        register file write data
//  we_pulse  out  1             register file write enable, single-cycle pulse
//  busy      out  1             high while a write (or init sweep) is in progress
//  init_done out  1             high once ready to accept requests
// BEHAVIOUR
//  Reset (reset==0 at posedge): gnt=0, W_Adr=0, Din=0, we_pulse=0, busy=0, RR pointer=0,
//   state=IDLE (or INIT with macro). Reset mid-write abandons it: we_pulse low next cycle, no gnt.
//  States: IDLE, WRITE (+ INIT with macro). All outputs registered.
//  IDLE: if |req, pick winner w = first set req[] at or after RR pointer, wrapping NREQ-1 -> 0;
//   register W_Adr=req_adr[w], Din=req_din[w], we_pulse=1, gnt[w]=1, busy=1; go WRITE.
//   If req==0: stay IDLE, we_pulse=0, gnt=0, busy=0.
//  WRITE (exactly 1 cycle): we_pulse=0, gnt=0; pointer <= (w+1) mod NREQ; go IDLE.
//  Latency: req seen in IDLE at edge t -> we_pulse+gnt high during cycle t+1; max 1 write / 2 cycles,
//   so we_pulse is always a true pulse (never high two consecutive cycles).
//  Requester must drop req (or present next op) on the edge where it samples gnt=1;
//   arbiter does not sample req during WRITE, so no double grant.
//  Fairness: with all NREQ requesting, grants rotate 0,1,..,NREQ-1,0; no requester waits > NREQ writes.
//  Simultaneous requests to same address: both written in grant order; last writer wins.
//  W_Adr/Din hold last issued values after we_pulse falls (not cleared).
//  init_done=1 immediately after reset (without macro).
// CONFIGURATION
//  REGFILE_ARB_INIT_EN defined: after reset, state=INIT; writes Din=0 to addresses 0..NREG-1
//   in ascending order, one we_pulse every 2 cycles (2*NREG cycles, 16 for defaults); req ignored,
//   gnt=0, busy=1, init_done=0 throughout; init_done=1 and state=IDLE the cycle after the last
//   pulse. Reset during sweep restarts it from address 0.
//  Not defined: no INIT state, no sweep; init_done tied 1 out of reset.
// STRUCTURE
//  Package regfile_pkg: ADR_W, DATA_W, NREG constants; state enum {ST_IDLE, ST_WRITE, ST_INIT}.
//  Sub-module regfile_rr_pick: combinational (req, ptr) -> (valid, winner index); reusable for read-port
//   arbitration. Top holds FSM, pointer, init counter, output registers.
// TESTING
//  1 Reset: hold reset=0 3 cycles with req=4'b1111 -> gnt=0, we_pulse=0, W_Adr=0, Din=0 each cycle.
//  2 Single: req=4'b0100, adr2=5, din2=4'hA -> next cycle we_pulse=1, gnt=4'b0100, W_Adr=5, Din=A;
//    following cycle we_pulse=0; read back R_Adr=5 shows A.
//  3 Round-robin: req=4'b1111 held (re-asserted after gnt) -> gnt order 0,1,2,3,0,1; we_pulse every
//    2nd cycle, never two in a row.
//  4 Wrap/skip: pointer at 3 after grant to 2, req=4'b0011 -> gnt[0] then gnt[1].
//  5 Mid-write reset: drop reset in WRITE cycle -> next cycle we_pulse=0, gnt=0, pointer=0.
//  6 INIT_EN build: release reset -> 8 pulses W_Adr=0..7, Din=0, init_done rises after 16 cycles;
//    req asserted during sweep granted only after init_done=1.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : regfile_pkg                                                     |
// | Purpose  : Shared constants, FSM state encoding and a round-robin helper   |
// |            for the register-file write-port arbiter.                       |
// | Contents : RF_ADR_W / RF_DATA_W / RF_NREG / RF_NREQ defaults, state_e,     |
// |            rr_next() pointer-advance helper.                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int RF_ADR_W  = 3;
  localparam int RF_DATA_W = 4;
  localparam int RF_NREG   = 1 << RF_ADR_W;
  localparam int RF_NREQ   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_INIT  = 2'd2
  } state_e;

  // Index following 'idx' in a ring of 'n' requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_rr_pick                                                 |
// | Purpose  : Combinational round-robin picker. Returns the first asserted    |
// |            request at or after the pointer, wrapping NREQ-1 -> 0.          |
// | Ports    : i_req   [NREQ]   request vector                                 |
// |            i_ptr   [IDX_W]  search start index (must be < NREQ)            |
// |            o_valid          at least one request asserted                  |
// |            o_idx   [IDX_W]  winning requester index                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_rr_pick
  import regfile_pkg::*;
#(
  parameter int NREQ  = RF_NREQ,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  int               w_cand;
  logic [IDX_W-1:0] w_sel;

  // Scan offsets from the far end back to zero so the smallest offset
  // (closest to the pointer) is the last assignment and therefore wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    w_sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      w_sel = IDX_W'(w_cand);
      if (i_req[w_sel]) begin
        o_valid = 1'b1;
        o_idx   = w_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter                                           |
// | Purpose  : Shares the single write port of the register file among NREQ   |
// |            requesters with round-robin arbitration. Issues one write every |
// |            two cycles at most and a one-cycle grant per issued write.      |
// | Ports    : clk        system clock (posedge)                               |
// |            reset      synchronous, active-low reset                        |
// |            req        per-requester request, held until grant              |
// |            req_adr    packed addresses, requester i at [i*ADR_W +: ADR_W]  |
// |            req_din    packed data, requester i at [i*DATA_W +: DATA_W]     |
// |            gnt        one-hot, one-cycle grant                             |
// |            W_Adr/Din  register file write address / data (held)            |
// |            we_pulse   register file write enable, single-cycle pulse       |
// |            busy       write or init sweep in progress                      |
// |            init_done  ready to accept requests                             |
// | Macro    : REGFILE_ARB_INIT_EN - after reset, sweep zeros into all         |
// |            registers before accepting requests.                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = RF_NREQ,
  parameter int ADR_W  = RF_ADR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADR_W-1:0]    req_adr,
  input  logic [NREQ*DATA_W-1:0]   req_din,
  output logic [NREQ-1:0]          gnt,
  output logic [ADR_W-1:0]         W_Adr,
  output logic [DATA_W-1:0]        Din,
  output logic                     we_pulse,
  output logic                     busy,
  output logic                     init_done
);

  localparam int IDX_W = $clog2(NREQ);

  state_e            r_state,  w_state_nxt;
  logic [IDX_W-1:0]  r_ptr,    w_ptr_nxt;
  logic [IDX_W-1:0]  r_winner, w_winner_nxt;
  logic [NREQ-1:0]   r_gnt,    w_gnt_nxt;
  logic [ADR_W-1:0]  r_adr,    w_adr_nxt;
  logic [DATA_W-1:0] r_din,    w_din_nxt;
  logic              r_we,     w_we_nxt;
  logic              r_busy,   w_busy_nxt;

  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;

  logic [ADR_W-1:0]  w_adr_arr [NREQ];
  logic [DATA_W-1:0] w_din_arr [NREQ];

`ifdef REGFILE_ARB_INIT_EN
  localparam int NREG = 1 << ADR_W;
  logic [ADR_W-1:0]  r_init_cnt,  w_init_cnt_nxt;
  logic              r_init_ph,   w_init_ph_nxt;
  logic              r_init_done, w_init_done_nxt;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_adr_arr[gi] = req_adr[gi*ADR_W +: ADR_W];
    assign w_din_arr[gi] = req_din[gi*DATA_W +: DATA_W];
  end

  regfile_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef REGFILE_ARB_INIT_EN
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_ph   <= 1'b0;
      r_init_done <= 1'b0;
`else
      r_state     <= ST_IDLE;
`endif
      r_ptr       <= '0;
      r_winner    <= '0;
      r_gnt       <= '0;
      r_adr       <= '0;
      r_din       <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
`ifdef REGFILE_ARB_INIT_EN
      r_init_cnt  <= w_init_cnt_nxt;
      r_init_ph   <= w_init_ph_nxt;
      r_init_done <= w_init_done_nxt;
`endif
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_winner    <= w_winner_nxt;
      r_gnt       <= w_gnt_nxt;
      r_adr       <= w_adr_nxt;
      r_din       <= w_din_nxt;
      r_we        <= w_we_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state / next-output logic. W_Adr and Din default to holding so the
  // last issued write stays visible after we_pulse falls.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_winner_nxt = r_winner;
    w_gnt_nxt    = '0;
    w_adr_nxt    = r_adr;
    w_din_nxt    = r_din;
    w_we_nxt     = 1'b0;
    w_busy_nxt   = 1'b0;
`ifdef REGFILE_ARB_INIT_EN
    w_init_cnt_nxt  = r_init_cnt;
    w_init_ph_nxt   = r_init_ph;
    w_init_done_nxt = r_init_done;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_winner_nxt          = w_pick_idx;
          w_gnt_nxt[w_pick_idx] = 1'b1;
          w_adr_nxt             = w_adr_arr[w_pick_idx];
          w_din_nxt             = w_din_arr[w_pick_idx];
          w_we_nxt              = 1'b1;
          w_busy_nxt            = 1'b1;
          w_state_nxt           = ST_WRITE;
        end
      end
      // Dead cycle after every write: req is not sampled here, which gives
      // the granted requester one edge to withdraw its request.
      ST_WRITE: begin
        w_ptr_nxt   = IDX_W'(rr_next(int'(r_winner), NREQ));
        w_state_nxt = ST_IDLE;
      end
`ifdef REGFILE_ARB_INIT_EN
      // Phase 0 issues a zero write to r_init_cnt, phase 1 is the gap cycle.
      ST_INIT: begin
        w_busy_nxt = 1'b1;
        if (!r_init_ph) begin
          w_adr_nxt     = r_init_cnt;
          w_din_nxt     = '0;
          w_we_nxt      = 1'b1;
          w_init_ph_nxt = 1'b1;
        end else begin
          w_init_ph_nxt = 1'b0;
          if (r_init_cnt == ADR_W'(NREG - 1)) begin
            w_busy_nxt      = 1'b0;
            w_init_done_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end else begin
            w_init_cnt_nxt = r_init_cnt + 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign gnt      = r_gnt;
  assign W_Adr    = r_adr;
  assign Din      = r_din;
  assign we_pulse = r_we;
  assign busy     = r_busy;
`ifdef REGFILE_ARB_INIT_EN
  assign init_done = r_init_done;
`else
  assign init_done = 1'b1;
`endif

endmodule
`default_nettype wire
